// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment serial transmitter.
//   seg7_state_e  : transmitter FSM states
//   SEG7_FRAME_W  : default frame width (8 digits x 8 segments)
//   SEG7_CLK_DIV  : default clk cycles per seg_clk half-period
package seg7_pkg;

  localparam int unsigned SEG7_FRAME_W = 64;
  localparam int unsigned SEG7_CLK_DIV = 2;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } seg7_state_e;

endpackage

// File: rtl/seg7_serial_tx_if.sv
// Frame handshake between the segment-remap stage and the serial transmitter.
//   start : frame request (master -> slave)
//   data  : frame bits in board order, MSB shifted first (master -> slave)
//   busy  : frame in flight (slave -> master)
//   done  : one-cycle completion pulse (slave -> master)
interface seg7_serial_tx_if #(
  parameter int unsigned DATA_W = seg7_pkg::SEG7_FRAME_W
) ();

  logic              start;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output data,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data,
    output busy,
    output done
  );

endinterface

// File: rtl/seg7_bit_timer.sv
// Half-period timer for the serial shift clock.
//   clk, rstn : system clock, synchronous active-low reset
//   enable    : run while high; held cleared (start of a low phase) while low
//   rise_tick : last cycle of the low phase (seg_clk goes high next edge)
//   fall_tick : last cycle of the high phase (seg_clk goes low next edge)
module seg7_bit_timer import seg7_pkg::*; #(
  parameter int unsigned CLK_DIV = SEG7_CLK_DIV
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned PhaseW = $clog2(CLK_DIV) + 1;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(CLK_DIV - 1);

  logic [PhaseW-1:0] phase_q;
  logic              high_q;  // which half of the bit period we are in
  logic              wrap;

  assign wrap      = enable && (phase_q == PhaseLast);
  assign rise_tick = wrap && !high_q;
  assign fall_tick = wrap && high_q;

  always_ff @(posedge clk) begin
    if (!rstn || !enable) begin
      phase_q <= '0;
      high_q  <= 1'b0;
    end else if (wrap) begin
      phase_q <= '0;
      high_q  <= ~high_q;
    end else begin
      phase_q <= phase_q + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_serial_tx.sv
// Serial transmitter for the 7-segment display shift-register chain.
//   clk, rstn : system clock, synchronous active-low reset
//   bus       : start/data request in, busy/done status out
//   seg_clk   : chain shift clock, data valid on its rising edge
//   seg_sout  : serial data, frame MSB first
//   seg_pen   : display enable, low while shifting, dark until first frame
//   seg_clrn  : chain clear, active low, released after reset
// All outputs are registered.
module seg7_serial_tx import seg7_pkg::*; #(
  parameter int unsigned DATA_W  = SEG7_FRAME_W,
  parameter int unsigned CLK_DIV = SEG7_CLK_DIV
) (
  input  logic            clk,
  input  logic            rstn,
  seg7_serial_tx_if.slave bus,
  output logic            seg_clk,
  output logic            seg_sout,
  output logic            seg_pen,
  output logic            seg_clrn
);

  localparam int unsigned BitCntW = $clog2(DATA_W) + 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

  seg7_state_e        state_q;
  logic [DATA_W-1:0]  sreg_q;
  logic [DATA_W-1:0]  sreg_shl;
  logic [BitCntW-1:0] bit_cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               timer_en;
  logic               rise_tick;
  logic               fall_tick;

  assign timer_en = (state_q == StShift);
  // Shifting a 1-bit frame yields 0, so DATA_W=1 needs no special case.
  assign sreg_shl = sreg_q << 1;

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  seg7_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (timer_en),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      seg_clk   <= 1'b0;
      seg_sout  <= 1'b0;
      seg_pen   <= 1'b0;
      seg_clrn  <= 1'b0;
    end else begin
      seg_clrn <= 1'b1;
      done_q   <= 1'b0;
      case (state_q)
        // DONE behaves like IDLE for acceptance so frames can run back-to-back.
        StIdle, StDone: begin
          if (bus.start) begin
            state_q   <= StShift;
            sreg_q    <= bus.data;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            seg_pen   <= 1'b0;
            seg_clk   <= 1'b0;
            seg_sout  <= bus.data[DATA_W-1];
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          if (rise_tick) begin
            seg_clk <= 1'b1;
          end else if (fall_tick) begin
            seg_clk <= 1'b0;
            if (bit_cnt_q == LastBit) begin
              state_q  <= StDone;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              seg_pen  <= 1'b1;
              seg_sout <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              sreg_q    <= sreg_shl;
              seg_sout  <= sreg_shl[DATA_W-1];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_serial_tx.sv
// Self-checking bench for seg7_serial_tx: a 64-bit/CLK_DIV=2 instance and an
// 8-bit/CLK_DIV=1 instance, each compared cycle by cycle against a timing
// model derived from frame position arithmetic.
module tb_seg7_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_a, rstn_b;
  logic a_sclk, a_sout, a_pen, a_clrn;
  logic b_sclk, b_sout, b_pen, b_clrn;

  seg7_serial_tx_if #(.DATA_W(64)) bus_a ();
  seg7_serial_tx_if #(.DATA_W(8))  bus_b ();

  seg7_serial_tx #(
    .DATA_W (64),
    .CLK_DIV(2)
  ) dut_a (
    .clk     (clk),
    .rstn    (rstn_a),
    .bus     (bus_a),
    .seg_clk (a_sclk),
    .seg_sout(a_sout),
    .seg_pen (a_pen),
    .seg_clrn(a_clrn)
  );

  seg7_serial_tx #(
    .DATA_W (8),
    .CLK_DIV(1)
  ) dut_b (
    .clk     (clk),
    .rstn    (rstn_b),
    .bus     (bus_b),
    .seg_clk (b_sclk),
    .seg_sout(b_sout),
    .seg_pen (b_pen),
    .seg_clrn(b_clrn)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic pen_idle [2];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output bundle order: {busy, done, seg_clk, seg_sout, seg_pen, seg_clrn}
  function automatic logic [5:0] get_outs(input int sel);
    if (sel == 1) return {bus_b.busy, bus_b.done, b_sclk, b_sout, b_pen, b_clrn};
    return {bus_a.busy, bus_a.done, a_sclk, a_sout, a_pen, a_clrn};
  endfunction

  task automatic drive(input int sel, input logic st, input logic [63:0] dat);
    if (sel == 1) begin
      bus_b.start = st;
      bus_b.data  = dat[7:0];
    end else begin
      bus_a.start = st;
      bus_a.data  = dat;
    end
  endtask

  task automatic set_rstn(input int sel, input logic v);
    if (sel == 1) rstn_b = v;
    else rstn_a = v;
  endtask

  task automatic idle_cycles(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      drive(sel, 1'b0, {$urandom, $urandom});
      @(negedge clk);
      check_val($sformatf("idle%0d outs", sel), 64'(get_outs(sel)),
                64'({5'b00000, 1'b1} | {4'b0000, pen_idle[sel], 1'b0}));
    end
  endtask

  // Requests frame d at the next edge (cycle 0) and checks cycles 1..N+1.
  // ign_at: cycle after which a stray start is driven; rst_at: cycle after
  // which reset is asserted; hold: keep start high through the DONE cycle.
  task automatic run_frame(input int sel, input logic [63:0] d, input int ign_at,
                           input int rst_at, input bit hold);
    int w, dv, n, k, nrise;
    logic [5:0] o, e;
    logic [63:0] got, mask, dat;
    logic prev, st;
    w     = (sel == 1) ? 8 : 64;
    dv    = (sel == 1) ? 1 : 2;
    n     = w * 2 * dv;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    got   = '0;
    nrise = 0;
    prev  = 1'b0;
    drive(sel, 1'b1, d);
    @(posedge clk);
    for (int t = 1; t <= n + 1; t++) begin
      @(negedge clk);
      o = get_outs(sel);
      if (t <= n) begin
        k = (t - 1) / (2 * dv);
        e = {1'b1, 1'b0, 1'(((t - 1) / dv) % 2), d[w-1-k], 1'b0, 1'b1};
      end else begin
        e = 6'b010011;
      end
      check_val($sformatf("frame%0d t=%0d outs", sel, t), 64'(o), 64'(e));
      if (!prev && o[3]) begin
        got = {got[62:0], o[2]};
        nrise++;
      end
      prev = o[3];
      if (t == rst_at) begin
        set_rstn(sel, 1'b0);
        drive(sel, 1'b0, '0);
        @(negedge clk);
        check_val($sformatf("rst%0d mid-frame outs", sel), 64'(get_outs(sel)), 64'd0);
        set_rstn(sel, 1'b1);
        @(negedge clk);
        check_val($sformatf("rst%0d release outs", sel), 64'(get_outs(sel)), 64'd1);
        pen_idle[sel] = 1'b0;
        return;
      end
      st  = hold || (t == ign_at);
      dat = (t == ign_at) ? 64'd0 : {$urandom, $urandom};
      if (t == n + 1) st = hold;
      drive(sel, st, dat);
    end
    pen_idle[sel] = 1'b1;
    check_val($sformatf("frame%0d rises", sel), 64'(nrise), 64'(w));
    check_val($sformatf("frame%0d bits", sel), got & mask, d & mask);
  endtask

  initial begin
    bit hold;
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    pen_idle[0] = 1'b0;
    pen_idle[1] = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("reset a outs", 64'(get_outs(0)), 64'd0);
      check_val("reset b outs", 64'(get_outs(1)), 64'd0);
    end
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    @(negedge clk);
    check_val("release a outs", 64'(get_outs(0)), 64'd1);
    check_val("release b outs", 64'(get_outs(1)), 64'd1);

    // Wide instance: directed frames
    idle_cycles(0, 2);
    run_frame(0, 64'h8000_0000_0000_0001, 0, 0, 1'b0);
    idle_cycles(0, 3);
    run_frame(0, 64'hFFFF_FFFF_FFFF_FFFF, 50, 0, 1'b0);
    idle_cycles(0, 2);
    run_frame(0, {$urandom, $urandom}, 0, 80, 1'b0);
    idle_cycles(0, 2);
    run_frame(0, 64'hA5A5_A5A5_A5A5_A5A5, 0, 0, 1'b0);
    idle_cycles(0, 1);
    run_frame(0, {$urandom, $urandom}, 0, 0, 1'b1);
    run_frame(0, {$urandom, $urandom}, 0, 0, 1'b0);
    idle_cycles(0, 2);
    // Wide instance: random frames with stray starts
    for (int i = 0; i < 4; i++) begin
      run_frame(0, {$urandom, $urandom}, int'($urandom_range(1, 256)), 0, 1'b0);
      idle_cycles(0, int'($urandom_range(0, 3)));
    end

    // Narrow, undivided instance
    idle_cycles(1, 1);
    run_frame(1, 64'hC3, 0, 0, 1'b0);
    idle_cycles(1, 2);
    run_frame(1, {$urandom, $urandom}, 0, 5, 1'b0);
    run_frame(1, 64'h5A, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      hold = (i < 19) && ($urandom_range(0, 3) == 0);
      run_frame(1, {$urandom, $urandom}, int'($urandom_range(0, 16)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 16)) : 0, hold);
      if (!hold) idle_cycles(1, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
